led_seq_ctrl: RTL and testbench
===============================

Name: led_seq_ctrl

Overview:
Controller that sequences the 8-bit LED display from the 50 MHz board clock. A free-running prescaler generates a 200 kHz square clock and a one-cycle step tick. A small FSM (IDLE/RUN/PAUSE) driven by Start/Stop pulses advances an 8-bit LED pattern register in one of four modes on each tick. It sits between the push-button front end and the LED pins.

Parameters:
DIV, 250, prescaler modulus in CLK_50MHz cycles (50 MHz / 250 = 200 kHz); must be even and at least 4.

Ports:
CLK_50MHz  input  1  system clock, rising-edge.
Res  input  1  asynchronous, active-high reset.
Start  input  1  synchronous request, sampled each edge; IDLE->RUN (load) or PAUSE->RUN (resume).
Stop  input  1  synchronous request; RUN->PAUSE or PAUSE->IDLE.
Mode  input  2  pattern select: 00 count up, 01 count down, 10 rotate left, 11 ping-pong.
LED  output  8  pattern register.
CLK_200KHz  output  1  prescaler square wave, 50% duty.
Tick  output  1  one-cycle pulse every DIV cycles.
Busy  output  1  high in RUN or PAUSE.

Behaviour:
- Reset (async): cnt=0, state=IDLE, LED=8'h00, mode_q=00, dir=left, CLK_200KHz=0, Tick=0, Busy=0.
- Prescaler: cnt counts 0..DIV-1 and wraps to 0. It runs regardless of FSM state.
- Tick = (cnt==DIV-1), decoded from the cnt register.
- CLK_200KHz = (cnt >= DIV/2): low for the first DIV/2 cycles, then high.
- IDLE state:
  - Start=1: go to RUN, latch mode_q=Mode, load LED per mode_q: 00->00, 01->FF, 10->01, 11->01 with dir=left.
  - A Tick on the load edge does not also step LED.
- RUN state:
  - On each Tick (with Stop=0), LED steps per mode_q:
    - 00: LED+1, 8-bit wrap FF->00.
    - 01: LED-1, wrap 00->FF.
    - 10: rotate left, 80->01.
    - 11: shift in dir. At 80, next is 40 and dir=right. At 01 (dir=right), next is 02 and dir=left. Ends are not repeated.
  - Stop=1: go to PAUSE. LED holds, and a Tick on that edge does not step.
- PAUSE state:
  - LED, mode_q and dir hold.
  - Start=1: go to RUN with no reload; stepping resumes on the next Tick.
  - Stop=1: go to IDLE and clear LED to 00.
- Start and Stop both high: Stop has priority in every state. In IDLE both inputs are ignored.
- Mode changes outside IDLE are ignored; mode_q only updates on load.
- Start while in RUN: no effect, no reload.
- Busy = (state != IDLE), registered together with state.
- Res asserted mid-run: all registers return to reset values immediately. After release, the prescaler phase restarts from cnt=0.
- Latency: Start sampled at edge n puts state=RUN and the loaded LED value visible after edge n. The first step occurs at the first edge after n where cnt==DIV-1.

Test Plan:
All scenarios use DIV=10.
1. Reset and prescaler: hold Res=1 for 3 cycles, then release. -> LED=00, Busy=0. Tick pulses on cycles 10, 20, ... after release. CLK_200KHz is low 5 cycles, then high 5 cycles.
2. Count up, with wrap: Mode=00, pulse Start. -> LED=00 then 01, 02, ... one step per Tick. Force the path through FF: after 256 Ticks, LED wraps FF->00.
3. Ping-pong: Mode=11, Start. -> LED sequence 01,02,04,...,80,40,20,...,01,02 with no repeated 80 or 01.
4. Pause and resume: Mode=01, Start, wait 3 Ticks (LED=FC), pulse Stop. -> LED holds FC across 5 Ticks with Busy=1. Change Mode to 10 and pulse Start. -> next Tick gives LED=FB (mode change ignored). Stop twice -> LED=00, Busy=0.
5. Collisions: Start with Tick on the same edge in IDLE. -> LED=01 for Mode=10, no step. Start+Stop together in RUN -> PAUSE. Start+Stop together in IDLE -> stays IDLE.
6. Reset mid-run: assert Res asynchronously between edges while LED=07. -> LED=00, Busy=0, CLK_200KHz=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: sequences an 8-bit LED pattern from the 50 MHz board clock.
//
// A free-running prescaler (modulus DIV) produces a 50% duty square wave
// (CLK_200KHz) and a one-cycle step pulse (Tick). A three-state FSM
// (IDLE/RUN/PAUSE) driven by Start/Stop advances the LED pattern once per
// Tick while running, using one of four modes latched at load time.
//
// Ports:
//   CLK_50MHz   in   1  system clock, rising edge
//   Res         in   1  asynchronous active-high reset
//   Start       in   1  IDLE->RUN (load) / PAUSE->RUN (resume)
//   Stop        in   1  RUN->PAUSE / PAUSE->IDLE (clears LED); wins over Start
//   Mode        in   2  00 up, 01 down, 10 rotate left, 11 ping-pong
//   LED         out  8  pattern register
//   CLK_200KHz  out  1  prescaler square wave, low first half of the period
//   Tick        out  1  one-cycle pulse while cnt == DIV-1
//   Busy        out  1  high in RUN or PAUSE
//
// DIV must be even and at least 4.
module led_seq_ctrl #(
  parameter int DIV = 250
) (
  input  logic       CLK_50MHz,
  input  logic       Res,
  input  logic       Start,
  input  logic       Stop,
  input  logic [1:0] Mode,
  output logic [7:0] LED,
  output logic       CLK_200KHz,
  output logic       Tick,
  output logic       Busy
);

  localparam int CW = (DIV > 2) ? $clog2(DIV) : 2;
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(DIV / 2);

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10
  } state_t;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;
  logic          sq_q, sq_d;
  state_t        state_q, state_d;
  logic [7:0]    led_q, led_d;
  logic [1:0]    mode_q, mode_d;
  logic          dir_q, dir_d;
  logic          busy_q, busy_d;
  logic [8:0]    step_s;

  // One step of the pattern; returns {next_dir, next_led}.
  function automatic logic [8:0] pattern_step(input logic [1:0] mode,
                                              input logic [7:0] led,
                                              input logic       dir);
    logic [8:0] r;
    r = {dir, led};
    case (mode)
      2'b00:   r = {dir, led + 8'h01};
      2'b01:   r = {dir, led - 8'h01};
      2'b10:   r = {dir, led[6:0], led[7]};
      2'b11: begin
        // Bounce at the ends without repeating the end value.
        if (dir == DIR_LEFT) begin
          if (led == 8'h80) begin
            r = {DIR_RIGHT, 8'h40};
          end else begin
            r = {DIR_LEFT, led[6:0], 1'b0};
          end
        end else begin
          if (led == 8'h01) begin
            r = {DIR_LEFT, 8'h02};
          end else begin
            r = {DIR_RIGHT, 1'b0, led[7:1]};
          end
        end
      end
      default: r = {dir, led};
    endcase
    return r;
  endfunction

  // Load value for a fresh start in the given mode.
  function automatic logic [7:0] pattern_load(input logic [1:0] mode);
    logic [7:0] v;
    case (mode)
      2'b00:   v = 8'h00;
      2'b01:   v = 8'hFF;
      2'b10:   v = 8'h01;
      2'b11:   v = 8'h01;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // Prescaler next state; Tick and the square wave are registered from the
  // next count so they line up exactly with the cnt register.
  always_comb begin
    cnt_d  = CNT_ZERO;
    if (cnt_q == CNT_LAST) begin
      cnt_d = CNT_ZERO;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
    tick_d = (cnt_d == CNT_LAST);
    sq_d   = (cnt_d >= CNT_HALF);
  end

  assign step_s = pattern_step(mode_q, led_q, dir_q);

  // FSM next state and pattern datapath.
  always_comb begin
    state_d = state_q;
    led_d   = led_q;
    mode_d  = mode_q;
    dir_d   = dir_q;
    case (state_q)
      ST_IDLE: begin
        if (Stop) begin
          state_d = ST_IDLE;
        end else if (Start) begin
          state_d = ST_RUN;
          mode_d  = Mode;
          dir_d   = DIR_LEFT;
          led_d   = pattern_load(Mode);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (Stop) begin
          state_d = ST_PAUSE;
        end else if (tick_q) begin
          {dir_d, led_d} = step_s;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_PAUSE: begin
        if (Stop) begin
          state_d = ST_IDLE;
          led_d   = 8'h00;
        end else if (Start) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_PAUSE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        led_d   = 8'h00;
        mode_d  = 2'b00;
        dir_d   = DIR_LEFT;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK_50MHz or posedge Res) begin
    if (Res) begin
      cnt_q   <= CNT_ZERO;
      tick_q  <= 1'b0;
      sq_q    <= 1'b0;
      state_q <= ST_IDLE;
      led_q   <= 8'h00;
      mode_q  <= 2'b00;
      dir_q   <= DIR_LEFT;
      busy_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      sq_q    <= sq_d;
      state_q <= state_d;
      led_q   <= led_d;
      mode_q  <= mode_d;
      dir_q   <= dir_d;
      busy_q  <= busy_d;
    end
  end

  assign LED        = led_q;
  assign CLK_200KHz = sq_q;
  assign Tick       = tick_q;
  assign Busy       = busy_q;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl with DIV=10. Expected LED values are
// queued when a sequence is started and popped as each step edge occurs.
module tb_led_seq_ctrl;

  logic       clk;
  logic       res;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [7:0] led;
  logic       clk200;
  logic       tick;
  logic       busy;

  int tests_run;
  int tests_failed;

  logic [7:0] exp_q[$];

  logic [7:0] pp_seq [16] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                              8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02, 8'h04};

  led_seq_ctrl #(.DIV(10)) dut (
    .CLK_50MHz (clk),
    .Res       (res),
    .Start     (start),
    .Stop      (stop),
    .Mode      (mode),
    .LED       (led),
    .CLK_200KHz(clk200),
    .Tick      (tick),
    .Busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clk_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Advance until Tick is seen (next edge is a step edge); bounded.
  task automatic wait_tick(input string name);
    int n;
    n = 0;
    while (tick !== 1'b1 && n < 25) begin
      clk_cycle();
      n++;
    end
    tests_run++;
    if (tick !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s: Tick timeout, got %b, expected 1", name, tick);
    end
  endtask

  task automatic next_step(input string name);
    logic [7:0] e;
    wait_tick(name);
    clk_cycle();
    if (exp_q.size() == 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL %s: scoreboard empty, got %h, expected a queued value", name, led);
    end else begin
      e = exp_q.pop_front();
      chk(name, led, e);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    clk_cycle();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    clk_cycle();
    stop = 1'b0;
  endtask

  task automatic test_reset();
    res = 1'b1;
    repeat (3) clk_cycle();
    chk("reset_led", led, 8'h00);
    chk("reset_busy", {7'd0, busy}, 8'h00);
    chk("reset_tick", {7'd0, tick}, 8'h00);
    chk("reset_clk200", {7'd0, clk200}, 8'h00);
    res = 1'b0;
    for (int e = 1; e <= 20; e++) begin
      clk_cycle();
      chk("presc_tick", {7'd0, tick}, ((e % 10) == 9) ? 8'h01 : 8'h00);
      chk("presc_clk200", {7'd0, clk200}, ((e % 10) >= 5) ? 8'h01 : 8'h00);
    end
    chk("presc_led_idle", led, 8'h00);
  endtask

  task automatic test_count_up();
    mode = 2'b00;
    pulse_start();
    chk("up_load", led, 8'h00);
    chk("up_busy", {7'd0, busy}, 8'h01);
    for (int i = 1; i <= 256; i++) exp_q.push_back(8'(i));
    for (int i = 0; i < 256; i++) next_step("up_step");
    pulse_stop();
    pulse_stop();
    chk("up_end_led", led, 8'h00);
    chk("up_end_busy", {7'd0, busy}, 8'h00);
  endtask

  task automatic test_ping_pong();
    mode = 2'b11;
    pulse_start();
    chk("pp_load", led, 8'h01);
    for (int i = 0; i < 16; i++) exp_q.push_back(pp_seq[i]);
    for (int i = 0; i < 16; i++) next_step("pp_step");
    pulse_stop();
    pulse_stop();
    chk("pp_end_busy", {7'd0, busy}, 8'h00);
  endtask

  task automatic test_pause_resume();
    mode = 2'b01;
    pulse_start();
    chk("down_load", led, 8'hFF);
    exp_q.push_back(8'hFE);
    exp_q.push_back(8'hFD);
    exp_q.push_back(8'hFC);
    for (int i = 0; i < 3; i++) next_step("down_step");
    pulse_stop();
    chk("pause_led", led, 8'hFC);
    for (int i = 0; i < 5; i++) begin
      wait_tick("pause_wait");
      clk_cycle();
      chk("pause_hold", led, 8'hFC);
      chk("pause_busy", {7'd0, busy}, 8'h01);
    end
    mode = 2'b10;
    pulse_start();
    chk("resume_noreload", led, 8'hFC);
    exp_q.push_back(8'hFB);
    next_step("resume_step");
    pulse_stop();
    pulse_stop();
    chk("stop2_led", led, 8'h00);
    chk("stop2_busy", {7'd0, busy}, 8'h00);
  endtask

  task automatic test_collisions();
    mode = 2'b10;
    wait_tick("coll_align");
    pulse_start();
    chk("coll_load_nostep", led, 8'h01);
    exp_q.push_back(8'h02);
    next_step("coll_rot");
    start = 1'b1;
    stop  = 1'b1;
    clk_cycle();
    start = 1'b0;
    stop  = 1'b0;
    chk("coll_run_busy", {7'd0, busy}, 8'h01);
    wait_tick("coll_pause_wait");
    clk_cycle();
    chk("coll_paused_hold", led, 8'h02);
    pulse_stop();
    chk("coll_idle_busy", {7'd0, busy}, 8'h00);
    start = 1'b1;
    stop  = 1'b1;
    clk_cycle();
    start = 1'b0;
    stop  = 1'b0;
    chk("coll_idle_stay", {7'd0, busy}, 8'h00);
    chk("coll_idle_led", led, 8'h00);
  endtask

  task automatic test_reset_mid_run();
    mode = 2'b00;
    pulse_start();
    for (int i = 1; i <= 7; i++) exp_q.push_back(8'(i));
    for (int i = 0; i < 7; i++) next_step("mid_step");
    repeat (6) clk_cycle();
    #3;
    res = 1'b1;
    #1;
    chk("async_led", led, 8'h00);
    chk("async_busy", {7'd0, busy}, 8'h00);
    chk("async_clk200", {7'd0, clk200}, 8'h00);
    #1;
    res = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      clk_cycle();
      chk("restart_tick", {7'd0, tick}, (e == 9) ? 8'h01 : 8'h00);
    end
    chk("restart_busy", {7'd0, busy}, 8'h00);
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    res   = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    mode  = 2'b00;
    test_reset();
    test_count_up();
    test_ping_pong();
    test_pause_resume();
    test_collisions();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
